// File: rtl/cascade_pkg.sv
// Shared types and helpers for the INTA cascade sequencer.
package cascade_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

    localparam logic [1:0] VB_CALL = 2'd0;
    localparam logic [1:0] VB_LOW  = 2'd1;
    localparam logic [1:0] VB_HIGH = 2'd2;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int unsigned onehot_to_bin(input logic [31:0] v);
        for (int unsigned i = 0; i < 32; i++) begin
            if (v[i]) begin
                return i;
            end
        end
        return 0;
    endfunction

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/cascade_edge_det.sv
// INTA edge detector: one registered sample of inta_n, fall/rise against it.
module cascade_edge_det (
    input  logic clk,
    input  logic inta_n,
    output logic fall,
    output logic rise
);

    logic prev;

    // Plain delay register; it keeps tracking inta_n through reset so that a
    // reset taken while INTA is low cannot manufacture a fall afterwards.
    always_ff @(posedge clk) begin
        prev <= inta_n;
    end

    assign fall = prev & ~inta_n;
    assign rise = ~prev & inta_n;

endmodule

// File: rtl/cascade_sequencer.sv
// INTA acknowledge sequencer: cascade ID drive/decode and vector byte gating.
module cascade_sequencer #(
    parameter int ID_W   = 3,
    parameter int N_IRQ  = 2**ID_W,
    parameter int TO_CYC = 64,
    parameter int TO_W   = $clog2(TO_CYC + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SP_EN,
    input  logic             sngl,
    input  logic             upm,
    input  logic [N_IRQ-1:0] icw3,
    input  logic [N_IRQ-1:0] ack_level,
    input  logic             inta_n,
    input  logic [ID_W-1:0]  CAS_IN,
    output logic [ID_W-1:0]  CAS_OUT,
    output logic             CAS_OE,
    output logic             send_vector_address,
    output logic [1:0]       vec_byte,
    output logic             seq_done,
    output logic             seq_abort,
    output logic             cas_err
);

    import cascade_pkg::*;

    logic fall, rise;

    cascade_edge_det u_edge (
        .clk    (clk),
        .inta_n (inta_n),
        .fall   (fall),
        .rise   (rise)
    );

    state_t            state_q, state_d;
    logic [1:0]        pcnt_q, pcnt_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              sending_q, sending_d;
    logic              cas_drive_q, cas_drive_d;
    logic              upm_q, upm_d;
    logic [ID_W-1:0]   cas_idx_q, cas_idx_d;

    logic [N_IRQ-1:0]  hit;
    logic [31:0]       hit_ext;
    logic              cascade_hit, multi_hit, timeout;
    logic [1:0]        last_pcnt;

    assign hit         = ack_level & icw3;
    assign hit_ext     = 32'(hit);
    assign cascade_hit = SP_EN & ~sngl & is_onehot(hit_ext);
    assign multi_hit   = SP_EN & ~sngl & (hit != '0) & ~is_onehot(hit_ext);
    assign last_pcnt   = upm_q ? 2'd2 : 2'd3;
    assign timeout     = (state_q != IDLE) && (to_q == TO_W'(TO_CYC));

    // State and per-sequence role registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pcnt_q      <= '0;
            to_q        <= '0;
            sending_q   <= 1'b0;
            cas_drive_q <= 1'b0;
            upm_q       <= 1'b0;
            cas_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            to_q        <= to_d;
            sending_q   <= sending_d;
            cas_drive_q <= cas_drive_d;
            upm_q       <= upm_d;
            cas_idx_q   <= cas_idx_d;
        end
    end

    // Next state, role capture at first fall, and the one-cycle status pulses.
    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        to_d        = to_q;
        sending_d   = sending_q;
        cas_drive_d = cas_drive_q;
        upm_d       = upm_q;
        cas_idx_d   = cas_idx_q;
        seq_done    = 1'b0;
        seq_abort   = 1'b0;
        cas_err     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d     = PULSE;
                    pcnt_d      = 2'd1;
                    to_d        = TO_W'(1);
                    upm_d       = upm;
                    cas_drive_d = cascade_hit;
                    cas_idx_d   = ID_W'(onehot_to_bin(hit_ext));
                    sending_d   = (SP_EN | sngl) ? ~cascade_hit
                                                 : (CAS_IN == icw3[ID_W-1:0]);
                    cas_err     = multi_hit;
                end
            end
            PULSE: begin
                to_d = to_q + TO_W'(1);
                if (rise) begin
                    if (pcnt_q == last_pcnt) begin
                        state_d  = IDLE;
                        pcnt_d   = '0;
                        to_d     = '0;
                        seq_done = 1'b1;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                to_d = to_q + TO_W'(1);
                if (fall) begin
                    state_d = PULSE;
                    pcnt_d  = pcnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d   = IDLE;
            pcnt_d    = '0;
            to_d      = '0;
            seq_done  = 1'b0;
            seq_abort = 1'b1;
        end
        if (!rst_n) begin
            seq_done  = 1'b0;
            seq_abort = 1'b0;
            cas_err   = 1'b0;
        end
    end

    // CAS drive and data-bus gating decoded from the current state.
    always_comb begin
        CAS_OE              = (state_q != IDLE) & cas_drive_q;
        CAS_OUT             = CAS_OE ? cas_idx_q : '0;
        send_vector_address = 1'b0;
        vec_byte            = VB_CALL;
        if (state_q == PULSE) begin
            if (sending_q) begin
                send_vector_address = upm_q ? (pcnt_q == 2'd2) : 1'b1;
            end else begin
                send_vector_address = cas_drive_q & ~upm_q & (pcnt_q == 2'd1);
            end
        end
        if (send_vector_address) begin
            if (upm_q) begin
                vec_byte = VB_LOW;
            end else begin
                case (pcnt_q)
                    2'd2:    vec_byte = VB_LOW;
                    2'd3:    vec_byte = VB_HIGH;
                    default: vec_byte = VB_CALL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cascade_sequencer.sv
// Self-checking bench for cascade_sequencer: directed scenario table, random
// scenarios against a timeline model, and a reset-mid-sequence sequence.
module tb_cascade_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, SP_EN, sngl, upm, inta_n;
    logic [7:0] icw3, ack_level;
    logic [2:0] CAS_IN, CAS_OUT;
    logic       CAS_OE, send_vector_address;
    logic [1:0] vec_byte;
    logic       seq_done, seq_abort, cas_err;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    cascade_sequencer #(.ID_W(3), .TO_CYC(64)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .SP_EN               (SP_EN),
        .sngl                (sngl),
        .upm                 (upm),
        .icw3                (icw3),
        .ack_level           (ack_level),
        .inta_n              (inta_n),
        .CAS_IN              (CAS_IN),
        .CAS_OUT             (CAS_OUT),
        .CAS_OE              (CAS_OE),
        .send_vector_address (send_vector_address),
        .vec_byte            (vec_byte),
        .seq_done            (seq_done),
        .seq_abort           (seq_abort),
        .cas_err             (cas_err)
    );

    // A scenario: configuration present at the first fall, INTA pulse shape,
    // and the expected role (CAS drive, ID, which pulses carry the vector).
    typedef struct {
        logic       sp_en, sngl, upm;
        logic [7:0] icw3, ack;
        logic [2:0] cas_in;
        int         np, w0, w1, w2, g0, g1;
        logic       exp_oe;
        logic [2:0] exp_cas;
        logic [2:0] exp_send;
        logic       exp_err;
    } scen_t;

    scen_t tbl[9];
    string tbl_name[9];

    function automatic scen_t mk(input logic sp, input logic sn, input logic up,
                                 input logic [7:0] i3, input logic [7:0] ak,
                                 input logic [2:0] ci, input int np,
                                 input int w0, input int w1, input int w2,
                                 input int g0, input int g1,
                                 input logic oe, input logic [2:0] ecas,
                                 input logic [2:0] esend, input logic eerr);
        scen_t s;
        s.sp_en = sp; s.sngl = sn; s.upm = up; s.icw3 = i3; s.ack = ak;
        s.cas_in = ci; s.np = np; s.w0 = w0; s.w1 = w1; s.w2 = w2;
        s.g0 = g0; s.g1 = g1; s.exp_oe = oe; s.exp_cas = ecas;
        s.exp_send = esend; s.exp_err = eerr;
        return s;
    endfunction

    // Reference role decision taken straight from the acknowledge rules.
    function automatic scen_t rand_scen();
        scen_t      s;
        logic [7:0] hit;
        int         last;
        s.sp_en  = 1'($urandom_range(0, 1));
        s.sngl   = ($urandom_range(0, 3) == 0);
        s.upm    = 1'($urandom_range(0, 1));
        s.icw3   = 8'($urandom);
        s.ack    = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                               : (8'd1 << $urandom_range(0, 7));
        s.cas_in = ($urandom_range(0, 1) == 1) ? s.icw3[2:0] : 3'($urandom);
        last     = s.upm ? 2 : 3;
        s.np     = ($urandom_range(0, 5) == 0) ? last - 1 : last;
        s.w0 = $urandom_range(1, 14); s.w1 = $urandom_range(1, 14);
        s.w2 = $urandom_range(1, 14); s.g0 = $urandom_range(1, 14);
        s.g1 = $urandom_range(1, 14);
        hit = s.ack & s.icw3;
        s.exp_oe = 1'b0; s.exp_cas = 3'd0; s.exp_err = 1'b0;
        if (!s.sp_en && !s.sngl) begin
            s.exp_send = (s.cas_in == s.icw3[2:0]) ? (s.upm ? 3'b010 : 3'b111) : 3'b000;
        end else if (!s.sngl && $countones(hit) == 1) begin
            s.exp_oe = 1'b1;
            for (int i = 0; i < 8; i++) if (hit[i]) s.exp_cas = 3'(i);
            s.exp_send = s.upm ? 3'b000 : 3'b001;
        end else begin
            s.exp_err  = !s.sngl && ($countones(hit) > 1);
            s.exp_send = s.upm ? 3'b010 : 3'b111;
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = {CAS_OUT, CAS_OE, send_vector_address, vec_byte, seq_done, seq_abort, cas_err};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %b want %b (cas_out,oe,send,vb,done,abort,err)",
                     name, $time, act, exp);
        end
    endtask

    task automatic rand_cfg();
        SP_EN = 1'($urandom_range(0, 1)); sngl = 1'($urandom_range(0, 1));
        upm = 1'($urandom_range(0, 1)); icw3 = 8'($urandom);
        ack_level = 8'($urandom); CAS_IN = 3'($urandom);
    endtask

    // Drives one scenario cycle by cycle; configuration is random on every
    // cycle except the first fall, so mid-sequence changes must be ignored.
    task automatic run_scen(input string name, input scen_t s);
        int   f[3], r[3], wl[3], gl[2];
        int   F, last, end_t, abort_t, stop_t, k;
        bit   aborted, act, inp, snd, w;
        logic [2:0] co;
        logic [1:0] vb;
        wl = '{s.w0, s.w1, s.w2};
        gl = '{s.g0, s.g1};
        F = 2;
        f[0] = F;         r[0] = f[0] + wl[0];
        f[1] = r[0] + gl[0]; r[1] = f[1] + wl[1];
        f[2] = r[1] + gl[1]; r[2] = f[2] + wl[2];
        last    = s.upm ? 2 : 3;
        end_t   = (s.np >= last) ? r[last - 1] : 32'h3fff_ffff;
        abort_t = F + 64;
        aborted = (end_t >= abort_t);
        stop_t  = aborted ? abort_t : end_t;
        for (int t = 0; t < stop_t + 4; t++) begin
            @(negedge clk);
            w = 1'b1;
            for (int kk = 0; kk < s.np; kk++)
                if (t >= f[kk] && t < r[kk] && t <= stop_t) w = 1'b0;
            inta_n = w;
            if (t == F) begin
                SP_EN = s.sp_en; sngl = s.sngl; upm = s.upm;
                icw3 = s.icw3; ack_level = s.ack; CAS_IN = s.cas_in;
            end else begin
                rand_cfg();
            end
            #1;
            act = (t > F) && (t <= stop_t);
            inp = 1'b0; k = 0;
            for (int kk = 0; kk < s.np; kk++)
                if (f[kk] < t && t <= r[kk] && t <= stop_t) begin inp = 1'b1; k = kk + 1; end
            co  = (act && s.exp_oe) ? s.exp_cas : 3'd0;
            snd = inp && s.exp_send[k - 1];
            vb  = snd ? (s.upm ? 2'd1 : 2'(k - 1)) : 2'd0;
            check(name, {co, act && s.exp_oe, snd, vb,
                         !aborted && t == end_t, aborted && t == abort_t,
                         (t == F) && s.exp_err});
        end
    endtask

    task automatic step(input logic in_n, input logic rn);
        @(negedge clk);
        inta_n = in_n;
        rst_n  = rn;
        #1;
    endtask

    initial begin
        tbl[0] = mk(1, 0, 1, 8'h04, 8'h04, 3'd0,   2,  3,  3, 0, 4, 0, 1, 3'b010, 3'b000, 0);
        tbl[1] = mk(1, 0, 1, 8'h00, 8'h10, 3'd0,   2,  2,  4, 0, 3, 0, 0, 3'b000, 3'b010, 0);
        tbl[2] = mk(0, 0, 0, 8'h05, 8'h00, 3'b101, 3,  3,  2, 4, 2, 5, 0, 3'b000, 3'b111, 0);
        tbl[3] = mk(0, 0, 0, 8'h05, 8'h00, 3'b011, 3,  3,  2, 4, 2, 5, 0, 3'b000, 3'b000, 0);
        tbl[4] = mk(1, 0, 1, 8'h06, 8'h06, 3'd0,   2,  3,  3, 0, 3, 0, 0, 3'b000, 3'b010, 1);
        tbl[5] = mk(1, 0, 1, 8'h00, 8'h01, 3'd0,   1,  4,  0, 0, 0, 0, 0, 3'b000, 3'b010, 0);
        tbl[6] = mk(1, 0, 0, 8'h80, 8'h80, 3'd0,   3,  2,  2, 2, 2, 2, 1, 3'b111, 3'b001, 0);
        tbl[7] = mk(1, 1, 0, 8'h00, 8'h00, 3'd0,   3,  1,  1, 1, 1, 1, 0, 3'b000, 3'b111, 0);
        tbl[8] = mk(1, 0, 1, 8'h00, 8'h00, 3'd0,   2, 30, 31, 0, 3, 0, 0, 3'b000, 3'b010, 0);
        tbl_name = '{"m86_casc", "m86_self", "s80_sel", "s80_nosel", "m_multi",
                     "timeout", "m80_casc", "single80", "coincident"};

        rst_n = 1'b0; inta_n = 1'b1;
        SP_EN = 1'b0; sngl = 1'b0; upm = 1'b0; icw3 = '0; ack_level = '0; CAS_IN = '0;
        repeat (3) @(negedge clk);
        check("reset_held", 10'b0);
        step(1'b1, 1'b1);
        check("reset_state", 10'b0);

        for (int i = 0; i < 9; i++) run_scen(tbl_name[i], tbl[i]);
        for (int i = 0; i < 40; i++) run_scen("random", rand_scen());

        // Reset during pulse 2 of an 8086 master-self sequence.
        SP_EN = 1'b1; sngl = 1'b0; upm = 1'b1; icw3 = '0; ack_level = '0; CAS_IN = '0;
        step(1'b0, 1'b1); check("rst_fall1", 10'b0);
        step(1'b0, 1'b1); check("rst_p1", 10'b0);
        step(1'b1, 1'b1); check("rst_rise1", 10'b0);
        step(1'b1, 1'b1); check("rst_gap", 10'b0);
        step(1'b0, 1'b1); check("rst_fall2", 10'b0);
        step(1'b0, 1'b1); check("rst_p2", 10'b000_0_1_01_000);
        step(1'b0, 1'b0); check("rst_low", 10'b000_0_1_01_000);
        step(1'b0, 1'b1); check("rst_after", 10'b0);
        step(1'b1, 1'b1); check("rst_rise_idle", 10'b0);
        step(1'b1, 1'b1); check("rst_idle", 10'b0);
        run_scen("rst_fresh", tbl[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
